// File: rtl/prio_level_stack_pkg.sv
// Shared sizing and types for the interrupt nesting controller and its level LIFO.
package prio_level_stack_pkg;

    localparam int PrioNum   = 8;
    localparam int PrioWidth = $clog2(PrioNum);
    localparam int Depth     = PrioNum - 1;
    localparam int NestWidth = $clog2(PrioNum + 1);

    typedef logic [PrioWidth-1:0] PrioT;
    typedef logic [NestWidth-1:0] NestT;

    // Strict unsigned comparison: only a higher level may preempt.
    function automatic logic preempts(input PrioT cand, input PrioT cur);
        return (cand > cur);
    endfunction

endpackage

// File: rtl/prio_level_stack_lifo.sv
// LIFO of preempted priority levels; reset clears the occupancy count only.
module prio_lifo #(
    parameter int Depth    = 7,
    parameter int Width    = 3,
    parameter int CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [Width-1:0]    pushData,
    output logic [Width-1:0]    top,
    output logic [CntWidth-1:0] count,
    output logic                full,
    output logic                empty
);

    localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]    mem_r [Depth];
    logic [CntWidth-1:0] count_r;

    assign count = count_r;
    assign full  = (count_r == CntWidth'(Depth));
    assign empty = (count_r == CntWidth'(0));

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CntWidth'(0);
        end else if (push && !full) begin
            count_r <= count_r + CntWidth'(1);
        end else if (pop && !empty) begin
            count_r <= count_r - CntWidth'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_r[IdxW'(count_r)] <= pushData;
        end
    end

    // Top-of-stack read.
    always_comb begin
        top = {Width{1'b0}};
        if (empty) begin
            top = {Width{1'b0}};
        end else begin
            top = mem_r[IdxW'(count_r - CntWidth'(1))];
        end
    end

endmodule

// File: rtl/prio_level_stack.sv
// Interrupt nesting controller: selects the active register bank level and strobes entry/return.
// Optional tail chaining on mret is enabled by defining PRIO_LEVEL_STACK_TAIL_CHAIN_EN.
module prio_level_stack
    import prio_level_stack_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 irq_req,
    input  logic [PrioWidth-1:0] irq_prio,
    input  logic                 mret,
    input  logic                 stall,
    output logic [PrioWidth-1:0] level,
    output logic                 write_ra_en,
    output logic                 irq_ack,
    output logic                 ret_ack,
    output logic [NestWidth-1:0] nest_depth,
    output logic                 err
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StEnter = 2'd1,
        StExit  = 2'd2
    } stateT;

    stateT state_r;
    stateT stateNext_s;
    PrioT  level_r;
    PrioT  levelNext_s;
    PrioT  top_s;
    NestT  count_s;
    logic  err_r;
    logic  errSet_s;
    logic  push_s;
    logic  pop_s;
    logic  full_s;
    logic  empty_s;
    logic  irqAck_r;
    logic  writeRa_r;
    logic  retAck_r;

    prio_lifo #(
        .Depth    (Depth),
        .Width    (PrioWidth),
        .CntWidth (NestWidth)
    ) u_lifo (
        .clk      (clk),
        .rst_n    (reset),
        .push     (push_s),
        .pop      (pop_s),
        .pushData (level_r),
        .top      (top_s),
        .count    (count_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    // State, level, sticky error and output strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= StRun;
            level_r   <= PrioT'(0);
            err_r     <= 1'b0;
            irqAck_r  <= 1'b0;
            writeRa_r <= 1'b0;
            retAck_r  <= 1'b0;
        end else begin
            state_r   <= stateNext_s;
            level_r   <= levelNext_s;
            err_r     <= err_r | errSet_s;
            irqAck_r  <= (stateNext_s == StEnter);
            writeRa_r <= (stateNext_s == StEnter);
            retAck_r  <= (stateNext_s == StExit);
        end
    end

    // Next-state: stall blocks everything, mret outranks a new interrupt.
    always_comb begin
        stateNext_s = StRun;
        levelNext_s = level_r;
        errSet_s    = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            StRun: begin
                if (stall) begin
                    stateNext_s = StRun;
                end else if (mret) begin
                    if (empty_s) begin
                        errSet_s = 1'b1;
`ifdef PRIO_LEVEL_STACK_TAIL_CHAIN_EN
                    end else if (irq_req && preempts(irq_prio, top_s)) begin
                        // Chained handler returns straight to the level below, so the LIFO is untouched.
                        levelNext_s = irq_prio;
                        stateNext_s = StEnter;
`endif
                    end else begin
                        pop_s       = 1'b1;
                        levelNext_s = top_s;
                        stateNext_s = StExit;
                    end
                end else if (irq_req && preempts(irq_prio, level_r)) begin
                    if (full_s) begin
                        errSet_s = 1'b1;
                    end else begin
                        push_s      = 1'b1;
                        levelNext_s = irq_prio;
                        stateNext_s = StEnter;
                    end
                end else begin
                    stateNext_s = StRun;
                end
            end
            StEnter, StExit: begin
                if (mret) begin
                    errSet_s = 1'b1;
                end else begin
                    errSet_s = 1'b0;
                end
            end
            default: begin
                stateNext_s = StRun;
            end
        endcase
    end

    assign level       = level_r;
    assign nest_depth  = count_s;
    assign err         = err_r;
    assign irq_ack     = irqAck_r;
    assign write_ra_en = writeRa_r;
    assign ret_ack     = retAck_r;

endmodule

// File: doc/prio_level_stack.md
Name: prio_level_stack

Overview:
- Interrupt nesting controller: the writer side of the per-priority banked register file.
- Decides when an interrupt preempts the current priority level.
- Drives the current level and the return-address-set strobe consumed by the register-file stack.
- Keeps a LIFO of preempted levels, restored on return-from-interrupt (mret), so nested handlers resume in the correct bank.

Parameters:
- PrioNum, 8: number of priority levels and register banks; level 0 is thread mode.
- PrioWidth, $clog2(PrioNum): width of a level value.
- Depth, PrioNum-1: LIFO entries; equals the maximum nesting depth.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- irq_req  in  1  pending interrupt valid, held until irq_ack
- irq_prio  in  PrioWidth  priority of pending interrupt
- mret  in  1  one-cycle pulse: return instruction retired
- stall  in  1  pipeline cannot redirect this cycle; blocks entry and exit
- level  out  PrioWidth  current level (register bank select)
- write_ra_en  out  1  one-cycle strobe: load return sentinel into ra of the new bank
- irq_ack  out  1  one-cycle pulse: interrupt taken
- ret_ack  out  1  one-cycle pulse: return completed
- nest_depth  out  $clog2(PrioNum+1)  occupied LIFO entries
- err  out  1  sticky: mret with empty LIFO, or push attempted when full

Behaviour:
- Reset (async assert): level=0, nest_depth=0, err=0, all strobes 0, FSM=RUN, LIFO contents don't-care.
- FSM states:
  - RUN: normal execution.
  - ENTER: one cycle; irq_ack=1, write_ra_en=1.
  - EXIT: one cycle; ret_ack=1.
- Strobes are registered outputs, high only in ENTER or EXIT.
- RUN, priority order each cycle:
  1. If stall, stay in RUN; mret and irq_req are not consumed. A mret pulse during stall is lost, so the core must hold mret with stall.
  2. If mret: pop. level <= top entry, nest_depth-1, go to EXIT. If nest_depth==0 instead: err<=1, level unchanged, stay in RUN.
  3. Else if irq_req and irq_prio > level (unsigned, strict): push current level, level <= irq_prio, nest_depth+1, go to ENTER. If nest_depth==Depth instead: err<=1, no change.
  4. Equal or lower irq_prio is ignored; irq_req stays pending.
- Timing: level changes on the same edge that enters ENTER or EXIT, so the strobe and the new level are visible in the same cycle.
- ENTER and EXIT always return to RUN next cycle, independent of stall.
  - mret arriving in ENTER or EXIT is a protocol error: ignored and err<=1.
  - This gives a minimum spacing of 2 cycles between level changes.
- Strict priority increase bounds depth at PrioNum-1, so overflow is reachable only through a design bug; it is still guarded.
- Deassertion of reset mid-ENTER or mid-EXIT: next cycle is RUN with reset values.

Optional Feature:
- Macro: PRIO_LEVEL_STACK_TAIL_CHAIN_EN.
- Defined: in RUN with mret and irq_req both high, and irq_prio > popped level:
  - No pop or push; level <= irq_prio, nest_depth unchanged, go to ENTER.
  - irq_ack and write_ra_en pulse; ret_ack does not pulse.
  - If irq_prio <= popped level, the normal mret path applies.
- Undefined: mret always wins. The irq is re-evaluated in RUN after EXIT, against the popped level.

Decomposition:
- config_pkg: PrioNum, PrioWidth, PrioT, and a new NestT (depth counter type).
- FSM state enum stays local to the module.
- One sub-module: prio_lifo.
  - Depth x PrioWidth register array with push/pop/top/count.
  - Async active-low reset clears count only.
  - Simultaneous push+pop is illegal at its interface.

Test Plan:
- Reset, then idle: level=0, nest_depth=0, no strobes for 10 cycles; assert reset mid-ENTER -> all outputs 0 immediately.
- Nesting: irq 3 at level 0 -> next cycle level=3, irq_ack=write_ra_en=1 for exactly 1 cycle, depth=1. Then irq 5 -> level=5, depth=2. Two mrets -> level 3 then 0, ret_ack each time, depth 0.
- Non-preemption: level=4, irq_prio=4 and 2 held 20 cycles -> no ack, level stays 4. mret -> level 0, then the pending irq 4 is taken 2 cycles later.
- Stall: irq 6 with stall=1 for 5 cycles -> no change. Stall drops -> ENTER on the next edge, level=6.
- Errors: mret at depth 0 -> err=1 and sticky, level 0. Mret during ENTER -> err=1.
- Tail chain (macro on): level 5 over 0, mret with irq 3 -> level=3, depth stays 1, irq_ack=1, ret_ack=0. Macro off: EXIT to 0, then ENTER to 3.
